// File: rtl/coax_tx_feeder.sv
// Buffered front end for coax_tx: a word FIFO plus a pacing FSM that turns the buffered
// words into one frame of edge-sensitive load strobes, honouring the transmitter's full/active.
module coax_tx_feeder #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [9:0]               write_data,
   input  logic                     write_strobe,
   input  logic                     start,
   input  logic                     tx_full,
   input  logic                     tx_active,
   output logic                     tx_load,
   output logic [9:0]               tx_data,
   output logic                     fifo_empty,
   output logic                     fifo_full,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

   typedef enum logic [2:0] {StIdle, StLoad, StGap, StCheck, StDrain} state_e;

   state_e          state_q;
   logic            seen_active_q;
   logic [9:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            wr_ok;
   logic            pop;

   // Acceptance depends only on occupancy at the start of the cycle, so a pop in the
   // same cycle never rescues a write into a full FIFO.
   assign wr_ok = write_strobe && (count_q < DepthCnt);
   assign pop   = (state_q == StLoad);

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == DepthCnt);
   assign fifo_count = count_q;
   assign busy       = (state_q != StIdle);

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr_q] <= write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (wr_ok && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (!wr_ok && pop) begin
            count_q <= count_q - 1'b1;
         end
         if (write_strobe && !wr_ok) begin
            overflow <= 1'b1;
         end
      end
   end

   // The head word is latched on the transition into LOAD; the pop happens during LOAD,
   // so CHECK sees the post-pop occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         tx_load       <= 1'b0;
         tx_data       <= '0;
         frame_done    <= 1'b0;
         seen_active_q <= 1'b0;
      end else begin
         tx_load    <= 1'b0;
         frame_done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start && !fifo_empty && !tx_active) begin
                  state_q       <= StLoad;
                  tx_load       <= 1'b1;
                  tx_data       <= mem[rd_ptr_q];
                  seen_active_q <= 1'b0;
               end
            end
            StLoad: begin
               if (tx_active) seen_active_q <= 1'b1;
               state_q <= StGap;
            end
            StGap: begin
               if (tx_active) seen_active_q <= 1'b1;
               state_q <= StCheck;
            end
            StCheck: begin
               if (tx_active) seen_active_q <= 1'b1;
               if (fifo_empty) begin
                  state_q <= StDrain;
               end else if (!tx_full) begin
                  state_q <= StLoad;
                  tx_load <= 1'b1;
                  tx_data <= mem[rd_ptr_q];
               end
            end
            StDrain: begin
               if (tx_active) begin
                  seen_active_q <= 1'b1;
               end else if (seen_active_q) begin
                  frame_done <= 1'b1;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_coax_tx_feeder.sv
// Directed bench for coax_tx_feeder: a simple transmitter stand-in on the tx side and a
// queue-based reference model checked against every DUT output each cycle.
module tb_coax_tx_feeder;

   localparam int unsigned DEPTH = 16;
   localparam int CW   = $clog2(DEPTH) + 1;
   localparam int WORD = 24;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [9:0]    write_data = '0;
   logic          write_strobe = 1'b0;
   logic          start = 1'b0;
   logic          tx_full = 1'b0;
   logic          tx_active = 1'b0;
   logic          tx_load;
   logic [9:0]    tx_data;
   logic          fifo_empty;
   logic          fifo_full;
   logic [CW-1:0] fifo_count;
   logic          busy;
   logic          frame_done;
   logic          overflow;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   int cap_q[$];

   always #5 clk = ~clk;

   coax_tx_feeder #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .write_data   (write_data),
      .write_strobe (write_strobe),
      .start        (start),
      .tx_full      (tx_full),
      .tx_active    (tx_active),
      .tx_load      (tx_load),
      .tx_data      (tx_data),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .fifo_count   (fifo_count),
      .busy         (busy),
      .frame_done   (frame_done),
      .overflow     (overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transmitter stand-in: one holding register, rising-edge capture, WORD cycles per word,
   // active rises two cycles after the first capture of a frame.
   bit lp, hv, on;
   int cnt, lead;
   always @(posedge clk) begin
      if (tx_load === 1'b1 && !lp) begin
         check("capture_while_full", 32'(hv), 0);
         if (!hv) begin
            hv = 1;
            cap_q.push_back(int'(tx_data));
            if (!on) begin
               on = 1;
               lead = 2;
            end
         end
      end
      lp = (tx_load === 1'b1);
      if (cnt > 0) cnt--;
      if (cnt == 0 && hv && lead == 0) begin
         cnt = WORD;
         hv = 0;
      end
      if (lead > 0) lead--;
      if (on && lead == 0 && cnt == 0 && !hv) on = 0;
      tx_full   <= hv;
      tx_active <= on && (lead == 0);
   end

   // Reference model: a word queue plus "cycles since last load" timing rules.
   int         mq[$];
   bit         m_valid, m_ovf, m_frame, m_drain, m_seen, m_load, m_done;
   int         m_since;
   logic [9:0] m_data;
   always @(posedge clk) begin : ref_model
      bit ld, dn, wr_ok;
      if (reset) begin
         mq.delete();
         m_ovf = 0; m_frame = 0; m_drain = 0; m_seen = 0;
         m_load = 0; m_done = 0; m_data = '0; m_since = 0; m_valid = 1;
      end else if (m_valid) begin
         ld = 0;
         dn = 0;
         if (!m_frame) begin
            if (start && mq.size() != 0 && !tx_active) begin
               ld = 1; m_frame = 1; m_drain = 0; m_seen = 0;
            end
         end else if (!m_drain) begin
            if (tx_active) m_seen = 1;
            if (m_since >= 2) begin
               if (mq.size() == 0) m_drain = 1;
               else if (!tx_full) ld = 1;
            end
         end else begin
            if (tx_active) m_seen = 1;
            else if (m_seen) begin
               dn = 1;
               m_frame = 0;
            end
         end
         if (ld) m_data = 10'(mq[0]);
         m_since = ld ? 0 : m_since + 1;
         wr_ok = (mq.size() < DEPTH);
         if (m_load) void'(mq.pop_front());
         if (write_strobe) begin
            if (wr_ok) mq.push_back(int'(write_data));
            else m_ovf = 1;
         end
         m_load = ld;
         m_done = dn;
      end
   end

   bit pf;
   always @(negedge clk) begin
      logic [20:0] expv, actv;
      if (m_valid) begin
         expv = {m_load, m_data, mq.size() == 0, mq.size() == DEPTH, CW'(mq.size()),
                 m_frame, m_done, m_ovf};
         actv = {tx_load, tx_data, fifo_empty, fifo_full, fifo_count, busy, frame_done, overflow};
         check("cycle_outputs", 32'(actv), 32'(expv));
         if (tx_load === 1'b1) check("load_after_full", 32'(pf), 0);
         if (frame_done === 1'b1) done_cnt++;
      end
      pf = tx_full;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [9:0] v);
      write_strobe = 1'b1;
      write_data   = v;
      tick();
      write_strobe = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit got = 0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) got = 1;
      end
      check({name, "_done_seen"}, 32'(got), 1);
      tick();
   endtask

   initial begin
      int d0;
      int s0;
      bit ok;
      logic [9:0] four[4];
      four[0] = 10'h001; four[1] = 10'h3FF; four[2] = 10'h2AA; four[3] = 10'h0F0;

      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_empty", 32'(fifo_empty), 1);
      check("rst_count", 32'(fifo_count), 0);
      check("rst_load", 32'(tx_load), 0);
      check("rst_data", 32'(tx_data), 0);
      check("rst_ovf", 32'(overflow), 0);
      tick();

      // Single word
      cap_q.delete();
      d0 = done_cnt;
      write_word(10'h155);
      pulse_start();
      @(negedge clk);
      check("single_load_n1", 32'(tx_load), 1);
      check("single_data_n1", 32'(tx_data), 32'h155);
      wait_done("single");
      repeat (5) tick();
      check("single_ncap", cap_q.size(), 1);
      check("single_word", cap_q[0], 32'h155);
      check("single_done_once", done_cnt - d0, 1);
      check("single_count", 32'(fifo_count), 0);

      // Four-word frame
      cap_q.delete();
      d0 = done_cnt;
      for (int i = 0; i < 4; i++) write_word(four[i]);
      pulse_start();
      wait_done("four");
      repeat (5) tick();
      check("four_ncap", cap_q.size(), 4);
      for (int i = 0; i < 4 && i < cap_q.size(); i++) check("four_word", cap_q[i], 32'(four[i]));
      check("four_done_once", done_cnt - d0, 1);

      // Start with an empty FIFO
      s0 = cap_q.size();
      pulse_start();
      repeat (3) tick();
      @(negedge clk);
      check("empty_start_busy", 32'(busy), 0);
      check("empty_start_ncap", cap_q.size(), s0);
      tick();

      // Overflow: 17 writes, last dropped
      cap_q.delete();
      for (int i = 0; i < 17; i++) write_word(10'(10'h040 + i));
      @(negedge clk);
      check("ovf_full", 32'(fifo_full), 1);
      check("ovf_count", 32'(fifo_count), 16);
      check("ovf_flag", 32'(overflow), 1);
      tick();
      pulse_start();
      wait_done("ovf");
      check("ovf_ncap", cap_q.size(), 16);
      if (cap_q.size() == 16) check("ovf_last", cap_q[15], 32'h04F);

      // Wrap-around: three 7-word frames
      cap_q.delete();
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 7; i++) write_word(10'(10'h100 + f * 7 + i));
         pulse_start();
         wait_done("wrap");
      end
      check("wrap_ncap", cap_q.size(), 21);
      for (int i = 0; i < 21 && i < cap_q.size(); i++) check("wrap_word", cap_q[i], 32'h100 + i);

      // Reset after the second load of a 5-word frame
      cap_q.delete();
      for (int i = 0; i < 5; i++) write_word(10'(10'h200 + i));
      pulse_start();
      ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (cap_q.size() >= 2) ok = 1;
      end
      check("rmf_second_load", 32'(ok), 1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rmf_load", 32'(tx_load), 0);
      check("rmf_count", 32'(fifo_count), 0);
      check("rmf_busy", 32'(busy), 0);
      tick();
      write_word(10'h3C3);
      check("rmf_active_still", 32'(tx_active), 1);
      pulse_start();
      repeat (2) tick();
      @(negedge clk);
      check("rmf_refused_busy", 32'(busy), 0);
      ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (tx_active === 1'b0) ok = 1;
      end
      check("rmf_active_fell", 32'(ok), 1);
      tick();
      pulse_start();
      @(negedge clk);
      check("rmf_accept_busy", 32'(busy), 1);
      check("rmf_accept_load", 32'(tx_load), 1);
      check("rmf_accept_data", 32'(tx_data), 32'h3C3);
      wait_done("rmf");
      check("rmf_ncap", cap_q.size(), 3);
      if (cap_q.size() == 3) check("rmf_words", cap_q[2], 32'h3C3);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
